sched_dispatch: RTL and testbench

- Dispatcher stage directly upstream of the two-processor scheduler block (`sched`).
- Accepts raw job release requests for tasks A and B and tracks occupancy of processors 0 and 1 from per-job durations counted in ticks.
- Produces the scheduler's input bundle: start_a/start_b, each paired with exactly one of sched0/sched1, plus a re-timed tick.
- Gives the scheduler a legal, non-conflicting assignment stream instead of a free-running environment.

---
 rtl/sched_pkg.sv | 19 +
 rtl/proc_timer.sv | 31 +++
 rtl/sched_dispatch.sv | 129 ++++++++++++
 tb/tb_sched_dispatch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and defaults for the scheduler dispatcher.
package sched_pkg;

    // Task identifiers; the value also serves as the round-robin pointer encoding.
    typedef enum logic {
        TASK_A = 1'b0,
        TASK_B = 1'b1
    } task_id_e;

    // Processor identifiers.
    localparam logic PROC0 = 1'b0;
    localparam logic PROC1 = 1'b1;

    // Default job durations (ticks) and remaining-time counter width.
    localparam int DUR_A_DEF = 3;
    localparam int DUR_B_DEF = 2;
    localparam int TW_DEF    = 4;

endpackage

// File: rtl/proc_timer.sv
// Per-processor remaining-time counter: loads a job duration, counts down on
// ticks and saturates at zero.
module proc_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick_in,
    output logic          busy,
    output logic          free
);

    logic [TW-1:0] rem;

    // Remaining time: a new job load takes priority over a same-cycle tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
        end else if (load) begin
            rem <= load_val;
        end else if (tick_in && (rem != '0)) begin
            rem <= rem - 1'b1;
        end
    end

    assign busy = (rem != '0);
    assign free = (rem == '0);

endmodule

// File: rtl/sched_dispatch.sv
// Dispatcher feeding the two-processor scheduler: arbitrates task A/B release
// requests onto free processors, holds one pending slot per task and flags
// dropped requests.
module sched_dispatch
    import sched_pkg::*;
#(
    parameter int DUR_A = DUR_A_DEF,
    parameter int DUR_B = DUR_B_DEF,
    parameter int TW    = TW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic tick_in,
    output logic start_a,
    output logic start_b,
    output logic sched0,
    output logic sched1,
    output logic tick,
    output logic busy0,
    output logic busy1,
    output logic overflow
);

    localparam logic [TW-1:0] LOAD_A = TW'(DUR_A);
    localparam logic [TW-1:0] LOAD_B = TW'(DUR_B);

    // Registered state
    logic     pend_a, pend_b;
    task_id_e rr;

    // Next-state / decision signals
    logic          free0, free1;
    logic          elig_a, elig_b;
    logic          disp, disp_a, disp_b;
    logic          proc_sel;
    task_id_e      win;
    task_id_e      rr_next;
    logic          pend_a_next, pend_b_next;
    logic          ovf_next;
    logic          load0, load1;
    logic [TW-1:0] load_val;

    proc_timer #(.TW(TW)) u_timer0 (
        .clk      (clk),
        .rst      (rst),
        .load     (load0),
        .load_val (load_val),
        .tick_in  (tick_in),
        .busy     (busy0),
        .free     (free0)
    );

    proc_timer #(.TW(TW)) u_timer1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load1),
        .load_val (load_val),
        .tick_in  (tick_in),
        .busy     (busy1),
        .free     (free1)
    );

    // Arbitration: pick the winning task, the lowest free processor, and the
    // next pending/overflow/round-robin values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        disp     = 1'b0;
        win      = TASK_A;
        rr_next  = rr;
        proc_sel = free0 ? PROC0 : PROC1;

        // A raw request bypasses the pending slot so a free processor is used at once.
        elig_a = pend_a | req_a;
        elig_b = pend_b | req_b;

        if ((free0 || free1) && (elig_a || elig_b)) begin
            disp = 1'b1;
            if (elig_a && elig_b) begin
                win     = rr;
                rr_next = (rr == TASK_A) ? TASK_B : TASK_A;
            end else begin
                win = elig_a ? TASK_A : TASK_B;
            end
        end

        disp_a = disp && (win == TASK_A);
        disp_b = disp && (win == TASK_B);

        // A request not served this cycle parks in the slot; a second one is dropped.
        pend_a_next = disp_a ? 1'b0 : (pend_a | req_a);
        pend_b_next = disp_b ? 1'b0 : (pend_b | req_b);
        ovf_next    = (req_a && pend_a && !disp_a) || (req_b && pend_b && !disp_b);

        load0    = disp && (proc_sel == PROC0);
        load1    = disp && (proc_sel == PROC1);
        load_val = (win == TASK_A) ? LOAD_A : LOAD_B;
    end

    // State and output registers; reset clears everything including pending requests.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            rr       <= TASK_A;
            start_a  <= 1'b0;
            start_b  <= 1'b0;
            sched0   <= 1'b0;
            sched1   <= 1'b0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pend_a   <= pend_a_next;
            pend_b   <= pend_b_next;
            rr       <= rr_next;
            start_a  <= disp_a;
            start_b  <= disp_b;
            sched0   <= load0;
            sched1   <= load1;
            tick     <= tick_in;
            overflow <= ovf_next;
        end
    end

endmodule

// File: tb/tb_sched_dispatch.sv
// Self-checking bench for sched_dispatch: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_sched_dispatch;

    localparam int DUR_A = 3;
    localparam int DUR_B = 2;
    localparam int TW    = 4;

    logic clk;
    logic rst;
    logic req_a, req_b, tick_in;
    logic start_a, start_b, sched0, sched1, tick, busy0, busy1, overflow;

    int n_checks = 0;
    int n_pass   = 0;

    sched_dispatch #(.DUR_A(DUR_A), .DUR_B(DUR_B), .TW(TW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .tick_in  (tick_in),
        .start_a  (start_a),
        .start_b  (start_b),
        .sched0   (sched0),
        .sched1   (sched1),
        .tick     (tick),
        .busy0    (busy0),
        .busy1    (busy1),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- Behavioural model ----------------
    // Processors hold remaining ticks, each task has one pending flag, and
    // pref is the task index that wins a tie.
    int m_rem[2];
    bit m_pend[2];
    int m_pref;
    bit e_start[2];
    bit e_sched[2];
    bit e_tick;
    bit e_ovf;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        bit req[2];
        bit want[2];
        int p;
        int win;
        req[0] = req_a;
        req[1] = req_b;
        e_start[0] = 0; e_start[1] = 0;
        e_sched[0] = 0; e_sched[1] = 0;
        e_ovf  = 0;
        e_tick = 0;
        if (rst) begin
            m_rem[0] = 0; m_rem[1] = 0;
            m_pend[0] = 0; m_pend[1] = 0;
            m_pref = 0;
            model_ok = 1'b1;
        end else begin
            for (int t = 0; t < 2; t++) want[t] = m_pend[t] || req[t];
            p = -1;
            for (int i = 1; i >= 0; i--) if (m_rem[i] == 0) p = i;
            win = -1;
            if (p >= 0) begin
                if (want[0] && want[1]) begin
                    win = m_pref;
                    m_pref = 1 - m_pref;
                end else if (want[0]) begin
                    win = 0;
                end else if (want[1]) begin
                    win = 1;
                end
            end
            for (int t = 0; t < 2; t++) begin
                if (t == win) begin
                    m_pend[t] = 0;
                end else if (req[t]) begin
                    if (m_pend[t]) e_ovf = 1;
                    m_pend[t] = 1;
                end
            end
            for (int q = 0; q < 2; q++) begin
                if (win >= 0 && q == p) m_rem[q] = (win == 0) ? DUR_A : DUR_B;
                else if (tick_in && m_rem[q] > 0) m_rem[q] = m_rem[q] - 1;
            end
            if (win >= 0) begin
                e_start[win] = 1;
                e_sched[p]   = 1;
            end
            e_tick = tick_in;
        end
    end

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("start_a",  start_a,  e_start[0]);
            check("start_b",  start_b,  e_start[1]);
            check("sched0",   sched0,   e_sched[0]);
            check("sched1",   sched1,   e_sched[1]);
            check("tick",     tick,     e_tick);
            check("overflow", overflow, e_ovf);
            check("busy0",    busy0,    m_rem[0] != 0);
            check("busy1",    busy1,    m_rem[1] != 0);
            check("one_hot_sched", 32'(sched0) + 32'(sched1), 32'(start_a) + 32'(start_b));
        end
    end

    // ---------------- Stimulus ----------------
    // Apply one cycle of inputs, then return just after the edge that consumed them.
    task automatic cycle(input logic r, input logic ra, input logic rb, input logic tk);
        rst     = r;
        req_a   = ra;
        req_b   = rb;
        tick_in = tk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int na;
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1; tick_in = 1'b1;

        // 1. Reset with all inputs high, then idle.
        cycle(1, 1, 1, 1);
        cycle(1, 1, 1, 1);
        check("rst_outputs", {start_a, start_b, sched0, sched1, tick, overflow, busy0, busy1}, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("post_rst_idle", {start_a, start_b, sched0, sched1, tick, overflow, busy0, busy1}, 0);

        // 2. Single A job with a tick every cycle.
        cycle(0, 1, 0, 1);
        check("single_start", {start_a, sched0, sched1, busy0}, 4'b1101);
        cycle(0, 0, 0, 1);
        check("single_pulse", {start_a, busy0}, 2'b01);
        cycle(0, 0, 0, 1);
        check("single_busy_c4", busy0, 1);
        cycle(0, 0, 0, 1);
        check("single_free_c5", busy0, 0);

        // 3. Back-to-back A then B, no ticks.
        cycle(0, 1, 0, 0);
        check("b2b_a", {start_a, start_b, sched0, sched1}, 4'b1010);
        cycle(0, 0, 1, 0);
        check("b2b_b", {start_a, start_b, sched0, sched1, busy0, busy1}, 6'b010111);
        repeat (3) cycle(0, 0, 0, 1);

        // 4. Contention, then again once idle: the preference alternates.
        cycle(0, 1, 1, 0);
        check("cont1_first", {start_a, start_b, sched0, sched1}, 4'b1010);
        cycle(0, 0, 0, 0);
        check("cont1_second", {start_a, start_b, sched0, sched1}, 4'b0101);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 1, 0);
        check("cont2_first_b", {start_a, start_b, sched0, sched1}, 4'b0110);
        cycle(0, 0, 0, 0);
        check("cont2_second_a", {start_a, start_b, sched0, sched1}, 4'b1001);
        repeat (3) cycle(0, 0, 0, 1);

        // 5. Both busy (A on 0, B on 1); a held A dispatches when B's processor frees.
        cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("both_busy_hold", {start_a, start_b}, 0);
        cycle(0, 0, 0, 1);
        check("both_busy_tick1", {start_a, busy1}, 2'b01);
        cycle(0, 0, 0, 1);
        check("both_busy_tick2", {start_a, busy1}, 2'b00);
        cycle(0, 0, 0, 0);
        check("pend_dispatch", {start_a, sched0, sched1}, 3'b101);
        repeat (3) cycle(0, 0, 0, 1);

        // 6. Overflow: second A request while one is already pending.
        cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("ovf_first_req", overflow, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("ovf_pulse", overflow, 1);
        cycle(0, 0, 0, 0);
        check("ovf_cleared", overflow, 0);
        na = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 1);
            na += int'(start_a);
        end
        check("ovf_one_start", na, 1);

        // Randomized traffic with occasional mid-job resets.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 1) == 1));
        end
        cycle(0, 0, 0, 0);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
